fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  64  fetch byte address; always 4-byte aligned.
REQ-008 imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_resp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 redirect_pc  input  64  redirect target.
REQ-012 instr_valid  output  1  instruction available to decode.
REQ-013 instr_ready  input  1  decode consumes the instruction this cycle.
REQ-014 instr  output  32  instruction word for decode.
REQ-015 instr_pc  output  64  address of instr.

Function
REQ-016 A request transfers when imem_req_valid and imem_req_ready are both high; fetch_pc then advances by 4, wrapping modulo 2^64.
REQ-017 imem_req_valid SHALL be high only in state RUN and only when outstanding + FIFO occupancy < FIFO_DEPTH, so a response is never dropped for lack of space.
REQ-018 Each response not marked for discard SHALL be pushed into the FIFO with its request address; zero-cycle bypass to instr is not provided, so minimum request-to-instr_valid latency is 2 cycles.
REQ-019 instr_valid = FIFO not empty; instr/instr_pc = head entry; pop on instr_valid && instr_ready.
REQ-020 redirect_valid SHALL, in the same cycle, force instr_valid and imem_req_valid low; next cycle the FIFO is empty, fetch_pc = redirect_pc, and kill_cnt = outstanding responses not returning in the redirect cycle.
REQ-021 While kill_cnt > 0, each response SHALL be discarded and kill_cnt decremented; new requests MAY issue meanwhile, subject to REQ-017 with killed responses counted as outstanding.
REQ-022 A redirect while kill_cnt > 0 SHALL add the current outstanding count to the kill total; redirect has priority over push, pop and request in the same cycle.
REQ-023 States: BOOT (first cycle after reset, no request) -> RUN; RUN -> HALT only under REQ-031; HALT -> RUN on an aligned redirect.
REQ-024 Outstanding counter width SHALL be clog2(FIFO_DEPTH)+1 bits; it never overflows or underflows.

Reset
REQ-025 On rst_n low: state = BOOT, fetch_pc = RESET_PC, FIFO empty, outstanding = 0, kill_cnt = 0.
REQ-026 During reset: imem_req_valid = 0, instr_valid = 0, instr = 32'h0, instr_pc = 64'h0, imem_req_addr = RESET_PC.
REQ-027 Reset asserted mid-transaction SHALL abandon all in-flight responses; the memory is reset by the same rst_n.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN selects misaligned-redirect handling.
REQ-029 With the macro defined, an additional port fetch_misaligned (output, 1) SHALL exist.
REQ-030 Without the macro, redirect_pc[1:0] SHALL be ignored (forced to 2'b00).
REQ-031 With the macro, a redirect with redirect_pc[1:0] != 0 SHALL enter HALT: no requests, fetch_misaligned = 1, and fetch_misaligned = 0 again after leaving HALT.

Structure
REQ-032 The fetch_state_t enum (BOOT, RUN, HALT) and the constant INSTR_BYTES = 4 SHALL live in the shared types package.
REQ-033 The buffer SHALL be a sub-module fetch_fifo, synchronous, depth FIFO_DEPTH, 96-bit entries {pc, instr}, with flush input.

Verification
REQ-034 Reset with RESET_PC = 64'h1000, ready = 1, 1-cycle response -> requests 0x1000, 0x1004, 0x1008; instr_pc follows in order, first instr_valid at cycle 3 after reset release.
REQ-035 instr_ready held low, FIFO_DEPTH = 2 -> exactly 2 requests issue, then imem_req_valid stays 0 until a pop.
REQ-036 Redirect to 0x2000 with 2 responses outstanding -> both discarded, next instr_pc = 0x2000, no stale instruction is visible.
REQ-037 Redirect coinciding with a response and a pop in one cycle -> response discarded, FIFO empty next cycle, kill_cnt correct.
REQ-038 With FETCH_MISALIGN_TRAP_EN: redirect to 0x2002 -> fetch_misaligned = 1, no requests; then redirect to 0x3000 -> resumes at 0x3000.
REQ-039 Reset asserted with 1 outstanding and a full FIFO -> all outputs at reset values immediately; restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   fetch_state_t : fetch control states (BOOT, RUN, HALT)
//   INSTR_BYTES   : size of one instruction word in bytes
//   align_pc()    : clears the sub-word bits of a byte address
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer, DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   flush       : empties the buffer on the next edge (wins over push/pop)
//   push        : write push_data at the tail
//   pop         : drop the head entry
//   head        : head entry (content undefined while empty)
//   empty       : no entries held
//   count       : number of entries held
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch front end. Issues sequential 4-byte fetch requests,
// buffers in-order responses with their addresses, and handles redirects by
// flushing the buffer and discarding responses still in flight.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- misaligned redirects halt
// fetch and raise fetch_misaligned; without it redirect_pc[1:0] is ignored.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   imem_req_valid/ready/addr         : fetch request channel
//   imem_resp_valid/data              : in-order response channel
//   redirect_valid/pc                 : redirect from execute
//   instr_valid/ready, instr, instr_pc: instruction channel to decode
//   fetch_misaligned (macro only)     : high while halted on a misaligned redirect
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | fetching sequentially
// HALT  | stopped after a misaligned redirect, waits for an aligned one
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [63:0]   fetch_pc, resp_pc, redir_target;
  logic [CW-1:0] outstanding, kill_cnt, fifo_count;
  logic [CW:0]   occupancy;
  logic          redir_misaligned, req_fire, resp_ret, resp_kill, resp_push;
  logic          fifo_empty, pop;
  logic [95:0]   fifo_head;

  assign redir_target = align_pc(redirect_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_misaligned = 1'b0;
`endif

  // Killed responses still count as outstanding so the buffer always has
  // room for every response that can come back.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_ret  = imem_resp_valid && (outstanding != '0);
  assign resp_kill = resp_ret && (kill_cnt != '0);
  assign resp_push = resp_ret && (kill_cnt == '0) && !redirect_valid;

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = !fifo_empty && !redirect_valid;
  assign pop           = instr_valid && instr_ready;
  assign instr         = fifo_empty ? 32'h0 : fifo_head[31:0];
  assign instr_pc      = fifo_empty ? 64'h0 : fifo_head[95:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_misaligned = 1'b0;
`endif
    case (state)
      BOOT: state_nxt = redir_misaligned ? HALT : RUN;
      RUN: begin
        imem_req_valid = !redirect_valid && (occupancy < (CW + 1)'(FIFO_DEPTH));
        if (redir_misaligned) state_nxt = HALT;
      end
      HALT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_misaligned = 1'b1;
`endif
        if (redirect_valid && !redir_misaligned) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // resp_pc tracks the address of the next live response: after a redirect
  // every live response belongs to the new sequential stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= align_pc(RESET_PC);
      resp_pc     <= align_pc(RESET_PC);
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_ret);
      if (redirect_valid) begin
        fetch_pc <= redir_target;
        resp_pc  <= redir_target;
        // no request can fire this cycle, so everything left in flight dies
        kill_cnt <= outstanding - CW'(resp_ret);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
        if (resp_kill) kill_cnt <= kill_cnt - CW'(1);
        if (resp_push) resp_pc  <= resp_pc + 64'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(96)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (resp_push),
    .push_data({resp_pc, imem_resp_data}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule
